mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that responds on the rv32i data-port bus (addr/wdata/wmask/wstrb/rstrb/rdata/rbusy/wbusy).
- Sits beside the data RAM, behind an external address decoder; the CPU is the initiator and this block is the responder.
- CPU writes bytes into an 8-entry FIFO; a serializer shifts them out as 8N1 frames on a single tx line.
- Provides a status register and a programmable baud divisor.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 2.
- DEFAULT_DIV, 16'd434, reset value of DIVISOR (clocks per bit).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- addr  input  32  byte address; only addr[3:2] decoded.
- wdata  input  32  write data.
- wmask  input  4  byte-lane write enables.
- wstrb  input  1  one-cycle write request.
- rstrb  input  1  one-cycle read request.
- rdata  output  32  read data.
- rbusy  output  1  read not yet complete; this block ties it to 0.
- wbusy  output  1  write stalled; initiator must not issue a new access while high.
- tx  output  1  serial output, idle high.
- irq  output  1  high while the FIFO is empty and the serializer is idle.

Behaviour:
- Reset (async) values:
  - rdata=0, wbusy=0, tx=1, irq=1.
  - FIFO empty, pointers 0, pending-write flag 0.
  - DIVISOR=DEFAULT_DIV; serializer in IDLE.
- Register map, selected by addr[3:2]:
  - 0 DATA: write pushes wdata[7:0] if wmask[0]; read returns 0.
  - 1 STATUS (read-only): bit0 full, bit1 empty, bit2 serializer busy, bits[7:4] FIFO count (saturating at 15); other bits 0.
  - 2 DIVISOR: bits[15:0]; byte lanes 0/1 written per wmask; read returns zero-extended value.
  - 3 reserved: reads 0, writes ignored.
- Reads:
  - rdata is registered on the edge sampling rstrb; valid from the next cycle.
  - rdata holds its value until the next rstrb.
  - Read latency is 1 cycle; rbusy is constant 0.
- Writes, FIFO not full:
  - Push on the edge sampling wstrb.
  - Count visible in STATUS on the following read.
- Writes to DATA, FIFO full:
  - Byte latched into the pending register; wbusy goes 1 from the next cycle.
  - Pending byte is pushed on the first edge a FIFO slot is free (same edge as the pop); wbusy drops the cycle after.
- wstrb and rstrb together: both serviced.
- wstrb while wbusy=1: ignored (protocol violation; assertion in the bench).
- A DATA write and a serializer pop on the same edge with FIFO full: the write pushes directly, no stall.
- Serializer FSM, states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty, pop into the shift register, go to START, tx=0.
  - START: hold for DIV clocks, then go to DATA (bit index 0).
  - DATA: tx = shift[0]; hold DIV clocks, shift right; after bit 7, go to STOP.
  - STOP: tx=1 for DIV clocks.
  - Exit from STOP: if FIFO non-empty, pop and go straight to START (back-to-back frames, no idle gap); else IDLE.
- DIV rules:
  - DIV = DIVISOR, with 0 treated as 1.
  - Bit counter reloads DIV-1 and counts to 0, so each bit lasts exactly DIV clocks.
  - A DIVISOR write during a frame takes effect at the next bit boundary.
- Frame timing: first start-bit clock begins the cycle after the pop edge; a frame lasts 10*DIV clocks.
- Reset mid-frame: tx returns to 1 immediately (async), FIFO is flushed, pending write is dropped.
- FIFO wrap-around: pointers are log2(FIFO_DEPTH)+1 bits; full when the MSBs differ and the rest are equal.

Decomposition:
- Shared package mmio_uart_pkg:
  - Register offsets REG_DATA=2'd0, REG_STATUS=2'd1, REG_DIV=2'd2.
  - STATUS bit indices.
  - Serializer state encoding (2-bit enum).
- One sub-module: sync_fifo (parameterised width/depth; push/pop/full/empty/count). It is reusable by a future receiver.

Test Plan:
- Reset, then read STATUS -> rdata=32'h0000_0002 the cycle after rstrb; tx=1, irq=1.
- DIVISOR=4, write DATA=0x55 -> tx low 4 clocks, then bits 1,0,1,0,1,0,1,0 (LSB first), 4 clocks each, then stop high 4 clocks; frame is 40 clocks; irq returns to 1.
- DIVISOR=2, write 9 bytes back-to-back:
  - Bytes 1-8 are accepted; the first pops at once.
  - Byte 9 is accepted without stall once the pop has freed a slot.
  - All 9 frames are contiguous (stop bit followed immediately by a start bit).
- DIVISOR=100, fill FIFO, write 0xA5 while full -> wbusy=1 from the next cycle until the current frame ends and the pop frees a slot; 0xA5 is transmitted last.
- DIVISOR=0 -> behaves as 1: a 10-clock frame for 0xFF.
- Assert rst mid-DATA bit with 3 queued -> tx=1 asynchronously, STATUS=0x2 after release; no further frames.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and serializer state encoding.
package mmio_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_BUSY    = 2;
    localparam int unsigned ST_CNT_LSB = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } ser_state_e;

    function automatic logic [3:0] sat_count4(input int unsigned n);
        return (n > 32'd15) ? 4'd15 : n[3:0];
    endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rv32i data-port bus as seen by a memory-mapped responder.
interface mmio_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wstrb;
    logic        rstrb;
    logic [31:0] rdata;
    logic        rbusy;
    logic        wbusy;

    modport master (output addr, wdata, wmask, wstrb, rstrb,
                    input  rdata, rbusy, wbusy);
    modport slave  (input  addr, wdata, wmask, wstrb, rstrb,
                    output rdata, rbusy, wbusy);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with extra-MSB wrap pointers.
// A push while full is accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, one-deep write stall
// buffer in front of the TX FIFO, and the bit serializer.
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic          clk,
    input  logic          rst,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          irq
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    ser_state_e    state_q, state_d;
    logic [15:0]   cnt_q, cnt_d, div_q, div_d, div_m1;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, pend_data_q, pend_data_d, push_data, fifo_rdata;
    logic          pend_q, pend_d, push, pop, fifo_full, fifo_empty, ser_busy;
    logic [CW-1:0] fifo_count;
    logic [31:0]   rdata_q, rd_val, status;
    logic [1:0]    sel;
    logic          wr_ok, data_wr;
    logic          unused_bits;

    assign sel         = bus.addr[3:2];
    assign wr_ok       = bus.wstrb && !pend_q;
    assign data_wr     = wr_ok && (sel == REG_DATA) && bus.wmask[0];
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:16], bus.wmask[3:2]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A pending byte has priority; a DATA write while full only stalls if
    // no pop frees a slot on the same edge.
    always_comb begin
        push        = 1'b0;
        push_data   = pend_data_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        if (pend_q) begin
            if (!fifo_full || pop) begin
                push   = 1'b1;
                pend_d = 1'b0;
            end
        end else if (data_wr) begin
            if (!fifo_full || pop) begin
                push      = 1'b1;
                push_data = bus.wdata[7:0];
            end else begin
                pend_d      = 1'b1;
                pend_data_d = bus.wdata[7:0];
            end
        end
    end

    always_comb begin
        div_d = div_q;
        if (wr_ok && (sel == REG_DIV)) begin
            if (bus.wmask[0]) div_d[7:0]  = bus.wdata[7:0];
            if (bus.wmask[1]) div_d[15:8] = bus.wdata[15:8];
        end
    end

    always_comb begin
        status                     = '0;
        status[ST_FULL]            = fifo_full;
        status[ST_EMPTY]           = fifo_empty;
        status[ST_BUSY]            = ser_busy;
        status[ST_CNT_LSB +: 4]    = sat_count4(32'(fifo_count));
        case (sel)
            REG_STATUS: rd_val = status;
            REG_DIV:    rd_val = {16'h0000, div_q};
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q     <= '0;
            div_q       <= DEFAULT_DIV;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
        end else begin
            if (bus.rstrb) rdata_q <= rd_val;
            div_q       <= div_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.rbusy = 1'b0;
    assign bus.wbusy = pend_q;

    assign div_m1 = (div_q == '0) ? '0 : div_q - 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = div_m1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    cnt_d   = div_m1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = div_m1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                // Chain straight into the next start bit when data is queued.
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        cnt_d   = div_m1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            S_START: tx = 1'b0;
            S_DATA:  tx = shift_q[0];
            default: tx = 1'b1;
        endcase
        ser_busy = (state_q != S_IDLE);
        irq      = fifo_empty && (state_q == S_IDLE);
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, back-to-back
// frames, full-FIFO stall, zero divisor and reset during a frame.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    import mmio_uart_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, irq;
    int   tests_run = 0;
    int   fails = 0;
    bit   rec = 1'b0;
    logic txlog[$];
    logic wblog[$];
    logic irqlog[$];

    always #5 clk = ~clk;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx),
        .irq (irq)
    );

    // log[k] holds the value after the k-th rising edge following rec=1
    always begin
        @(posedge clk);
        #2;
        if (rec) begin
            txlog.push_back(tx);
            wblog.push_back(bus.wbusy);
            irqlog.push_back(irq);
        end
    end

    always @(posedge clk)
        assert (rst || !(bus.wstrb && bus.wbusy)) else $error("protocol violation: wstrb while wbusy");

    task automatic bus_access(input logic w, input logic r, input logic [1:0] s,
                              input logic [31:0] d, input logic [3:0] m);
        bus.addr  = {28'h0, s, 2'b00};
        bus.wdata = d;
        bus.wmask = m;
        bus.wstrb = w;
        bus.rstrb = r;
        @(negedge clk);
        bus.wstrb = 1'b0;
        bus.rstrb = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] s, input logic [31:0] d, input logic [3:0] m);
        bus_access(1'b1, 1'b0, s, d, m);
    endtask

    task automatic bus_read(input logic [1:0] s);
        bus_access(1'b0, 1'b1, s, 32'h0, 4'h0);
    endtask

    task automatic start_log();
        txlog.delete();
        wblog.delete();
        irqlog.delete();
        rec = 1'b1;
    endtask

    function automatic int find_start(input int from);
        for (int i = from; i < txlog.size(); i++)
            if (txlog[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic void decode(input int s, input int d, output logic [7:0] data, output bit ok);
        logic v;
        data = '0;
        ok = (s >= 0) && (s + 10 * d <= txlog.size());
        if (!ok) return;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < d; j++) begin
                v = txlog[s + k * d + j];
                if (k == 0 && v !== 1'b0) ok = 1'b0;
                if (k == 9 && v !== 1'b1) ok = 1'b0;
                if (k >= 1 && k <= 8) begin
                    if (j == 0) data[k-1] = v;
                    else if (v !== data[k-1]) ok = 1'b0;
                end
            end
        end
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
        tests_run++; if (irq !== 1'b1) begin fails++; $display("FAIL reset_irq: got %b expected 1", irq); end
        tests_run++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", bus.rdata); end
        tests_run++; if (bus.wbusy !== 1'b0 || bus.rbusy !== 1'b0) begin fails++; $display("FAIL reset_busy: got w=%b r=%b expected 0 0", bus.wbusy, bus.rbusy); end
        rst = 1'b0;
        @(negedge clk);
        bus_read(REG_STATUS);
        tests_run++; if (bus.rdata !== 32'h2) begin fails++; $display("FAIL reset_status: got %h expected 00000002", bus.rdata); end
    endtask

    task automatic test_registers();
        bus_read(REG_DIV);
        tests_run++; if (bus.rdata !== 32'h1B2) begin fails++; $display("FAIL div_default: got %h expected 000001b2", bus.rdata); end
        bus_write(REG_DIV, 32'h1234_5678, 4'b0010);
        bus_read(REG_DIV);
        tests_run++; if (bus.rdata !== 32'h56B2) begin fails++; $display("FAIL div_lane1: got %h expected 000056b2", bus.rdata); end
        bus_write(2'd3, 32'hFFFF_FFFF, 4'hF);
        bus_read(2'd3);
        tests_run++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL reserved_read: got %h expected 0", bus.rdata); end
        bus_write(REG_DATA, 32'h0000_00AA, 4'b1110);
        bus_read(REG_STATUS);
        tests_run++; if (bus.rdata !== 32'h2) begin fails++; $display("FAIL data_no_lane0: got %h expected 00000002", bus.rdata); end
        bus_read(REG_DATA);
        tests_run++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL data_read: got %h expected 0", bus.rdata); end
        bus_access(1'b1, 1'b1, REG_DIV, 32'h0000_0004, 4'b0011);
        tests_run++; if (bus.rdata !== 32'h56B2) begin fails++; $display("FAIL rw_same_cycle: got %h expected 000056b2", bus.rdata); end
        bus_read(REG_DIV);
        repeat (3) @(negedge clk);
        tests_run++; if (bus.rdata !== 32'h4) begin fails++; $display("FAIL rdata_hold: got %h expected 00000004", bus.rdata); end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        bit ok;
        start_log();
        bus_write(REG_DATA, 32'h55, 4'h1);
        repeat (50) @(negedge clk);
        rec = 1'b0;
        tests_run++; if (find_start(0) !== 1) begin fails++; $display("FAIL frame55_start: got %0d expected 1", find_start(0)); end
        decode(1, 4, b, ok);
        tests_run++; if (!ok || b !== 8'h55) begin fails++; $display("FAIL frame55_data: got %h ok=%b expected 55 ok=1", b, ok); end
        tests_run++; if (txlog[41] !== 1'b1 || find_start(41) !== -1) begin fails++; $display("FAIL frame55_after: got %b expected 1", txlog[41]); end
        tests_run++; if (irqlog[40] !== 1'b0 || irqlog[41] !== 1'b1) begin fails++; $display("FAIL frame55_irq: got %b%b expected 01", irqlog[40], irqlog[41]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [9] = '{8'h01, 8'h80, 8'h3C, 8'hC3, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h99};
        logic [7:0] b;
        bit ok;
        bus_write(REG_DIV, 32'h2, 4'b0011);
        start_log();
        for (int i = 0; i < 9; i++) begin
            bus_write(REG_DATA, {24'h0, vals[i]}, 4'h1);
            tests_run++; if (bus.wbusy !== 1'b0) begin fails++; $display("FAIL b2b_wbusy[%0d]: got %b expected 0", i, bus.wbusy); end
        end
        bus_read(REG_STATUS);
        tests_run++; if (bus.rdata !== 32'h85) begin fails++; $display("FAIL b2b_status: got %h expected 00000085", bus.rdata); end
        repeat (200) @(negedge clk);
        rec = 1'b0;
        tests_run++; if (find_start(0) !== 1) begin fails++; $display("FAIL b2b_first: got %0d expected 1", find_start(0)); end
        for (int i = 0; i < 9; i++) begin
            decode(1 + 20 * i, 2, b, ok);
            tests_run++; if (!ok || b !== vals[i]) begin fails++; $display("FAIL b2b_frame[%0d]: got %h ok=%b expected %h ok=1", i, b, ok, vals[i]); end
        end
        tests_run++; if (find_start(181) !== -1) begin fails++; $display("FAIL b2b_extra: got start at %0d expected none", find_start(181)); end
    endtask

    task automatic test_full_stall();
        logic [7:0] b;
        bit ok;
        bus_write(REG_DIV, 32'd100, 4'b0011);
        start_log();
        for (int i = 0; i < 9; i++) bus_write(REG_DATA, 32'h10 + i, 4'h1);
        bus_write(REG_DATA, 32'hA5, 4'h1);
        repeat (10100) @(negedge clk);
        rec = 1'b0;
        tests_run++; if (wblog[8] !== 1'b0 || wblog[9] !== 1'b1) begin fails++; $display("FAIL stall_rise: got %b%b expected 01", wblog[8], wblog[9]); end
        tests_run++; if (wblog[1000] !== 1'b1 || wblog[1001] !== 1'b0) begin fails++; $display("FAIL stall_fall: got %b%b expected 10", wblog[1000], wblog[1001]); end
        decode(1, 100, b, ok);
        tests_run++; if (!ok || b !== 8'h10) begin fails++; $display("FAIL stall_frame0: got %h ok=%b expected 10 ok=1", b, ok); end
        decode(8001, 100, b, ok);
        tests_run++; if (!ok || b !== 8'h18) begin fails++; $display("FAIL stall_frame8: got %h ok=%b expected 18 ok=1", b, ok); end
        decode(9001, 100, b, ok);
        tests_run++; if (!ok || b !== 8'hA5) begin fails++; $display("FAIL stall_last: got %h ok=%b expected a5 ok=1", b, ok); end
        tests_run++; if (find_start(10001) !== -1) begin fails++; $display("FAIL stall_extra: got start at %0d expected none", find_start(10001)); end
    endtask

    task automatic test_div_zero();
        logic [7:0] b;
        bit ok;
        bus_write(REG_DIV, 32'h0, 4'b0011);
        bus_read(REG_DIV);
        tests_run++; if (bus.rdata !== 32'h0) begin fails++; $display("FAIL div0_read: got %h expected 0", bus.rdata); end
        start_log();
        bus_write(REG_DATA, 32'hFF, 4'h1);
        repeat (20) @(negedge clk);
        rec = 1'b0;
        decode(find_start(0), 1, b, ok);
        tests_run++; if (find_start(0) !== 1 || !ok || b !== 8'hFF) begin fails++; $display("FAIL div0_frame: got start=%0d %h ok=%b expected start=1 ff ok=1", find_start(0), b, ok); end
        tests_run++; if (irqlog[10] !== 1'b0 || irqlog[11] !== 1'b1) begin fails++; $display("FAIL div0_len: got irq %b%b expected 01", irqlog[10], irqlog[11]); end
    endtask

    task automatic test_reset_midframe();
        bus_write(REG_DIV, 32'd100, 4'b0011);
        bus_write(REG_DATA, 32'h00, 4'h1);
        bus_write(REG_DATA, 32'h11, 4'h1);
        bus_write(REG_DATA, 32'h22, 4'h1);
        bus_write(REG_DATA, 32'h33, 4'h1);
        repeat (150) @(negedge clk);
        tests_run++; if (tx !== 1'b0) begin fails++; $display("FAIL midframe_tx: got %b expected 0", tx); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (tx !== 1'b1 || irq !== 1'b1) begin fails++; $display("FAIL async_reset: got tx=%b irq=%b expected 1 1", tx, irq); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus_read(REG_STATUS);
        tests_run++; if (bus.rdata !== 32'h2) begin fails++; $display("FAIL flush_status: got %h expected 00000002", bus.rdata); end
        bus_read(REG_DIV);
        tests_run++; if (bus.rdata !== 32'h1B2) begin fails++; $display("FAIL reset_div: got %h expected 000001b2", bus.rdata); end
        start_log();
        repeat (300) @(negedge clk);
        rec = 1'b0;
        tests_run++; if (find_start(0) !== -1) begin fails++; $display("FAIL no_more_frames: got start at %0d expected none", find_start(0)); end
    endtask

    initial begin
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wmask = '0;
        bus.wstrb = 1'b0;
        bus.rstrb = 1'b0;
        test_reset();
        test_registers();
        test_single_frame();
        test_back_to_back();
        test_full_stall();
        test_div_zero();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
